// File: rtl/bitrev_reorder_buffer.sv
// Frame reorder buffer: a natural-order frame is stored at bit-reversed addresses and then read out in natural order.
// Define BITREV_PINGPONG_EN to get two banks (fill one while draining the other); the default is one bank.
module bitrev_reorder_buffer #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};
`ifdef BITREV_PINGPONG_EN
  localparam int NBANK = 2;
  localparam int AW    = LOG2N + 1;
`else
  localparam int NBANK = 1;
  localparam int AW    = LOG2N;
  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
`endif

  logic [DATA_W-1:0] mem_q [NBANK*N];

  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [LOG2N-1:0]  out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;

  logic [LOG2N-1:0]  wr_rev_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     rd_addr_s;
  logic              wr_hs_s;
  logic              wr_wrap_s;
  logic              out_acc_s;
  logic              last_acc_s;
  logic              slot_free_s;
  logic              rd_avail_s;
  logic              rd_load_s;

  // Write address is the arrival count with its bits mirrored (pure wiring).
  for (genvar i = 0; i < LOG2N; i++) begin : g_rev
    assign wr_rev_s[i] = wr_cnt_q[LOG2N-1-i];
  end

  assign wr_hs_s     = in_valid && in_ready_q;
  assign wr_wrap_s   = wr_hs_s && (wr_cnt_q == LAST_IDX);
  assign out_acc_s   = out_valid_q && out_ready;
  assign last_acc_s  = out_acc_s && (out_index_q == LAST_IDX);
  assign slot_free_s = !out_valid_q || out_ready;
  assign rd_load_s   = slot_free_s && rd_avail_s;

`ifdef BITREV_PINGPONG_EN
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;

  assign wr_addr_s  = {wr_bank_q, wr_rev_s};
  assign rd_addr_s  = {rd_bank_q, rd_cnt_q};
  // A bank counts as free once its last word has moved into the output register.
  assign rd_avail_s = full_q[rd_bank_q];

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_wrap_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
    if (rd_load_s && (rd_cnt_q == LAST_IDX)) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
    in_ready_d = !(full_d[0] && full_d[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end
`else
  logic [0:0] state_q, state_d;

  assign wr_addr_s  = wr_rev_s;
  assign rd_addr_s  = rd_cnt_q;
  // Once index N-1 sits in the output register nothing is left to fetch.
  assign rd_avail_s = (state_q == ST_DRAIN) && !(out_valid_q && (out_index_q == LAST_IDX));

  always_comb begin
    state_d    = state_q;
    in_ready_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready_d = !wr_wrap_s;
        if (wr_wrap_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (last_acc_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    if (wr_hs_s) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (rd_load_s) begin
      out_data_d  = mem_q[rd_addr_s];
      out_index_d = rd_cnt_q;
      out_valid_d = 1'b1;
      rd_cnt_d    = rd_cnt_q + LOG2N'(1);
    end else if (out_acc_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    out_last_d   = out_valid_d && (out_index_d == LAST_IDX);
    frame_done_d = last_acc_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      in_ready_q   <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sample storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_hs_s && !rst) begin
      mem_q[wr_addr_s] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Scoreboard bench for bitrev_reorder_buffer: accepted frames are reordered by a reference model
// into an expected queue that a negedge monitor drains on each output handshake.
module tb_bitrev_reorder_buffer;
  localparam int DW = 16;
  localparam int L  = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [L-1:0]  out_index;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          frame_done;

  bitrev_reorder_buffer #(.DATA_W(DW), .LOG2N(L)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] frame_buf[$];
  int fd_cycles[$];
  int rmode = 0;
  int stall_n = 0;
  bit t3_on = 1'b0;
  bit watch_ir = 1'b0;
  int exp_idx = 0;
  bit fd_exp = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [L-1:0] prev_index;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < L; i++) if (((v >> i) & 1) != 0) r += 1 << (L - 1 - i);
    return r;
  endfunction

  // Reference: sample k of a frame emerges at output position brev(k).
  task automatic model_accept(input logic [DW-1:0] d);
    frame_buf.push_back(d);
    if (frame_buf.size() == N) begin
      for (int n = 0; n < N; n++) exp_q.push_back(frame_buf[brev(n)]);
      frame_buf.delete();
    end
  endtask

  // Called aligned to posedge+#1; returns aligned to posedge+#1 after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input int gap_pct);
    int t = 0;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) break;
    end
    if (t > 500) timeout_fail("send_wait");
    else model_accept(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) timeout_fail("drain");
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1));
        2: out_ready = !out_ready;
        3: begin
          if (out_valid && out_index == 6'd10 && stall_n < 5) begin
            out_ready = 1'b0;
            stall_n++;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_idx    = 0;
      fd_exp     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_cycles.push_back(cyc);
      fd_exp = 1'b0;
      if (watch_ir) chk("in_ready_hold", 32'(in_ready), 32'd1);
      if (out_valid) begin
        chk("out_last", 32'(out_last), 32'(out_index == 6'd63));
        if (prev_stall) begin
          chk("hold_data", 32'(out_data), 32'(prev_data));
          chk("hold_index", 32'(out_index), 32'(prev_index));
        end
        if (t3_on && out_index == 6'd10) chk("stall_val", 32'(out_data), 32'h14);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            timeout_fail("unexpected_output");
          end else begin
            chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            chk("out_index", 32'(out_index), 32'(exp_idx));
            if (exp_idx == N - 1) fd_exp = 1'b1;
            exp_idx = (exp_idx + 1) % N;
          end
        end
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_index = out_index;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    in_valid = 1'b0;
    in_data  = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_post", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Natural ramp, continuous valid, ready high.
    rmode = 0;
    fd_cycles.delete();
    for (int k = 0; k < N; k++) send(DW'(k), 0);
    wait_drain();
    chk("t1_frame_done_count", 32'(fd_cycles.size()), 32'd1);

    // Same frame with 50% input gaps and random ready.
    rmode = 1;
    for (int k = 0; k < N; k++) send(DW'(k), 50);
    wait_drain();

    // Output stall at index 10.
    rmode = 3; stall_n = 0; t3_on = 1'b1;
    for (int k = 0; k < N; k++) send(DW'(k), 0);
    wait_drain();
    t3_on = 1'b0;
    chk("t3_stall_cycles", 32'(stall_n), 32'd5);

`ifndef BITREV_PINGPONG_EN
    // Junk input offered during drain must be refused.
    rmode = 0;
    for (int k = 0; k < N; k++) send(DW'(16'h0300 + k), 0);
    in_data = 16'hFFFF; in_valid = 1'b1; t = 0;
    forever begin
      @(negedge clk);
      if (out_valid) chk("t4_in_ready_drain", 32'(in_ready), 32'd0);
      if (frame_done || t > 500) break;
      t++;
    end
    in_valid = 1'b0;
    if (t > 500) timeout_fail("t4_frame_done");
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) send(DW'(200 + k), 0);
    wait_drain();
`endif

    // Reset after 30 samples discards the partial frame.
    rmode = 1;
    for (int k = 0; k < 30; k++) send(DW'($urandom_range(16'hFFFE)), 0);
    rst = 1'b1;
    frame_buf.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) send(DW'(100 + k), 0);
    wait_drain();

    // Back-to-back random frames with ready toggling every cycle.
    rmode = 2;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++) send(DW'($urandom), 0);
    wait_drain();

`ifdef BITREV_PINGPONG_EN
    // Three streaming frames: input never stalls after the first frame.
    rmode = 0;
    fd_cycles.delete();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        send(DW'($urandom), 0);
        if (f == 0 && k == N - 1) watch_ir = 1'b1;
      end
    end
    watch_ir = 1'b0;
    wait_drain();
    chk("t6_frame_done_count", 32'(fd_cycles.size()), 32'd3);
    if (fd_cycles.size() == 3) begin
      chk("t6_spacing_a", 32'(fd_cycles[1] - fd_cycles[0]), 32'd64);
      chk("t6_spacing_b", 32'(fd_cycles[2] - fd_cycles[1]), 32'd64);
    end
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
